// File: rtl/psram_512x64.sv
// 512 x 64 single-clock pseudo-two-port RAM with separate read and write ports.
// Includes a per-bit write mask, per-word valid tracking, and deep-sleep/power-gate modes.
module psram_512x64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        cenA,
  input  logic        cenB,
  input  logic        deepsleep,
  input  logic        powergate,
  input  logic [8:0]  aA,
  input  logic [8:0]  aB,
  input  logic [63:0] d,
  input  logic [63:0] bw,
  output logic [63:0] q
);

  logic [63:0]  mem_q [512];
  logic [511:0] valid_q;
  logic [63:0]  q_q;

  logic         normal_op;
  logic         wr_en;
  logic         rd_en;
  logic [63:0]  old_word;
  logic [63:0]  wr_word;
  logic [63:0]  rd_word;

  always_comb begin
    normal_op = !rst && !powergate && !deepsleep;
    wr_en     = normal_op && !cenB;
    rd_en     = normal_op && !cenA;
    // Invalid words merge as zero so stale array bits never leak back out.
    old_word  = valid_q[aB] ? mem_q[aB] : 64'h0;
    wr_word   = (old_word & ~bw) | (d & bw);
    rd_word   = valid_q[aA] ? mem_q[aA] : 64'h0;
  end

  // Array data carries no reset; the valid vector masks it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[aB] <= wr_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || powergate) begin
      valid_q <= '0;
      q_q     <= 64'h0;
    end else if (!deepsleep) begin
      if (wr_en) begin
        valid_q[aB] <= 1'b1;
      end
      // Nonblocking read samples pre-write contents on an address collision.
      if (rd_en) begin
        q_q <= rd_word;
      end
    end
  end

  assign q = q_q;

endmodule

// File: tb/tb_psram_512x64.sv
// Directed self-checking bench for psram_512x64 with a cycle-level behavioural memory model.
module tb_psram_512x64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cenA = 1'b1;
  logic        cenB = 1'b1;
  logic        deepsleep = 1'b0;
  logic        powergate = 1'b0;
  logic [8:0]  aA = '0;
  logic [8:0]  aB = '0;
  logic [63:0] d = '0;
  logic [63:0] bw = '0;
  logic [63:0] q;

  int n_total = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  psram_512x64 dut (
    .clk       (clk),
    .rst       (rst),
    .cenA      (cenA),
    .cenB      (cenB),
    .deepsleep (deepsleep),
    .powergate (powergate),
    .aA        (aA),
    .aB        (aB),
    .d         (d),
    .bw        (bw),
    .q         (q)
  );

  always #5 clk = ~clk;

  // Behavioural model: word store plus valid flags, updated at every rising edge.
  logic [63:0] m_mem [512];
  bit          m_valid [512];
  logic [63:0] exp_q = 64'h0;

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nd,
                                        input logic [63:0] mask);
    logic [63:0] r;
    for (int i = 0; i < 64; i++) r[i] = mask[i] ? nd[i] : old[i];
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst || powergate) begin
      for (int i = 0; i < 512; i++) m_valid[i] <= 1'b0;
      exp_q <= 64'h0;
    end else if (!deepsleep) begin
      if (!cenA) exp_q <= m_valid[aA] ? m_mem[aA] : 64'h0;
      if (!cenB) begin
        m_mem[aB]   <= merge(m_valid[aB] ? m_mem[aB] : 64'h0, d, bw);
        m_valid[aB] <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      n_total++;
      if (q !== exp_q) begin
        n_bad++;
        $display("FAIL cycle_compare t=%0t q=%h expected=%h", $time, q, exp_q);
      end
    end
  end

  task automatic drive(input bit r, input bit pg, input bit ds, input bit ca, input logic [8:0] a_a,
                       input bit cb, input logic [8:0] a_b, input logic [63:0] dd,
                       input logic [63:0] m);
    @(negedge clk);
    rst = r; powergate = pg; deepsleep = ds;
    cenA = ca; aA = a_a; cenB = cb; aB = a_b; d = dd; bw = m;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [8:0] a, input logic [63:0] dd, input logic [63:0] m);
    drive(0, 0, 0, 1, 9'h0, 0, a, dd, m);
  endtask

  task automatic rd(input logic [8:0] a);
    drive(0, 0, 0, 0, a, 1, 9'h0, 64'h0, 64'h0);
  endtask

  task automatic check_lit(input string name, input logic [63:0] expv);
    n_total++;
    if (q !== expv) begin
      n_bad++;
      $display("FAIL %s q=%h expected=%h", name, q, expv);
    end
  endtask

  localparam logic [63:0] Full = {64{1'b1}};

  initial begin
    drive(1, 0, 0, 1, 9'h0, 1, 9'h0, 64'h0, 64'h0);
    drive(1, 0, 0, 0, 9'h5, 0, 9'h5, 64'h77, Full);
    chk_en = 1'b1;
    check_lit("reset_q", 64'h0);

    rd(9'h5);
    check_lit("read_after_reset", 64'h0);

    wr(9'h1A5, 64'hDEAD_BEEF_0123_4567, Full);
    rd(9'h1A5);
    check_lit("full_write_read", 64'hDEAD_BEEF_0123_4567);

    wr(9'h0, 64'h1111_2222_3333_4444, Full);
    wr(9'h0, Full, 64'h0000_0000_0000_FF00);
    rd(9'h0);
    check_lit("byte_lane_merge", 64'h1111_2222_3333_FF44);

    wr(9'd20, Full, 64'h0000_0000_0000_00FF);
    rd(9'd20);
    check_lit("partial_on_invalid", 64'h0000_0000_0000_00FF);

    wr(9'd21, Full, 64'h0);
    rd(9'd21);
    check_lit("zero_mask_write", 64'h0);

    wr(9'd7, 64'hA, Full);
    drive(0, 0, 0, 0, 9'd7, 0, 9'd7, 64'hB, Full);
    check_lit("collision_old", 64'hA);
    rd(9'd7);
    check_lit("collision_new", 64'hB);

    drive(0, 0, 0, 0, 9'd0, 0, 9'd1, 64'h123, Full);
    check_lit("indep_read", 64'h1111_2222_3333_FF44);
    rd(9'd1);
    check_lit("indep_write", 64'h123);

    wr(9'd511, 64'h5A5A_0000_A5A5_FFFF, Full);
    rd(9'd511);
    check_lit("top_address", 64'h5A5A_0000_A5A5_FFFF);

    wr(9'd3, 64'h33, Full);
    rd(9'd3);
    drive(0, 0, 1, 0, 9'd7, 0, 9'd3, 64'h5, Full);
    check_lit("deepsleep_hold_q", 64'h33);
    drive(0, 0, 1, 0, 9'd1, 1, 9'd0, 64'h0, 64'h0);
    check_lit("deepsleep_hold_q2", 64'h33);
    rd(9'd7);
    check_lit("deepsleep_exit_read", 64'hB);
    rd(9'd3);
    check_lit("deepsleep_retained", 64'h33);

    rd(9'h1A5);
    drive(0, 1, 0, 0, 9'h1A5, 0, 9'd4, 64'h44, Full);
    check_lit("powergate_q", 64'h0);
    begin
      logic [8:0] addrs [6];
      addrs = '{9'd0, 9'd1, 9'd3, 9'd7, 9'h1A5, 9'd511};
      foreach (addrs[i]) begin
        rd(addrs[i]);
        check_lit("powergate_cleared", 64'h0);
      end
    end
    rd(9'd4);
    check_lit("powergate_write_dropped", 64'h0);

    wr(9'd9, 64'h99, Full);
    rd(9'd9);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 1, 9'(i + 100), 1, 9'h0, 64'h0, 64'h0);
      check_lit("cena_hold", 64'h99);
    end

    drive(1, 0, 0, 0, 9'd9, 0, 9'd9, 64'hEE, Full);
    check_lit("reset_mid_q", 64'h0);
    rd(9'd9);
    check_lit("reset_write_discarded", 64'h0);

    drive(0, 0, 0, 1, 9'h0, 1, 9'h0, 64'h0, 64'h0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/psram_512x64.md
PSRAM_512X64 -- requirements
Module: psram_512x64

Interface
REQ-001 Parameters: none; fixed geometry 512 words x 64 bits, 9-bit address.
REQ-002 clk  input  1  single clock for both ports; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 cenA  input  1  read-port enable, active-low (0 = read this cycle).
REQ-005 cenB  input  1  write-port enable, active-low (0 = write this cycle).
REQ-006 deepsleep  input  1  retention sleep, active-high.
REQ-007 powergate  input  1  power-down, active-high; contents lost.
REQ-008 aA  input  9  read word address.
REQ-009 aB  input  9  write word address.
REQ-010 d  input  64  write data.
REQ-011 bw  input  64  per-bit write enable; bit i = 1 writes d[i], bit i = 0 keeps the stored bit.
REQ-012 q  output  64  registered read data.

Function
REQ-013 Storage: 512 x 64-bit array plus a 512-bit per-word valid vector; a word with valid = 0 reads as 64'h0.
REQ-014 Priority each cycle, highest first: rst, then powergate, then deepsleep, then normal operation.
REQ-015 Write, normal operation, cenB = 0 at an edge: for every i, word[aB][i] <= bw[i] ? d[i] : word[aB][i], and valid[aB] <= 1.
REQ-016 Partial-write merge: the unmasked bits of a previously invalid word merge with 0.
REQ-017 Write with bw = 0: no bits change, but the word is still marked valid.
REQ-018 Read, normal operation, cenA = 0 at an edge: q <= valid[aA] ? word[aA] : 0.
REQ-019 Read latency: exactly 1 cycle; data is visible on q after the sampling edge.
REQ-020 cenA = 1: q holds its previous value.
REQ-021 Same-cycle read and write to the same address (aA == aB, both enabled): read-before-write; q returns the pre-write contents; the write is applied; the next read returns the new data.
REQ-022 Reads and writes to different addresses in the same cycle are fully independent.
REQ-023 Address range: all 9-bit addresses 0..511 are valid; no wrap or out-of-range case exists.
REQ-024 deepsleep = 1 (powergate = 0): reads and writes are ignored, array and valid vector are retained, q holds.
REQ-025 Leaving deepsleep: normal operation resumes on the next edge and prior contents are intact.
REQ-026 powergate = 1: at each edge the valid vector clears to all 0 and q <= 0; reads and writes are ignored.
REQ-027 After powergate deasserts, every word reads 0 until it is rewritten.
REQ-028 q is a pure register output; no combinational path from any input to q.

Reset
REQ-029 While rst = 1 at an edge: q <= 64'h0, valid vector <= all 0, and all reads and writes are ignored.
REQ-030 Array data bits need no reset; they are masked by the valid vector.
REQ-031 After rst deasserts: first read of any address returns 64'h0; normal operation starts on the first edge with rst = 0.
REQ-032 Reset mid-operation: a write presented in the same cycle as rst = 1 is discarded.

Verification
REQ-033 Full write then read: after reset, write d = 64'hDEAD_BEEF_0123_4567 with bw = all 1 to aB = 9'h1A5, then read aA = 9'h1A5 -> q = 64'hDEAD_BEEF_0123_4567 one cycle after the read edge.
REQ-034 Byte-lane merge: word 0 = 64'h1111_2222_3333_4444; write d = 64'hFFFF_FFFF_FFFF_FFFF with bw = 64'h0000_0000_0000_FF00 -> read 0 returns 64'h1111_2222_3333_FF44.
REQ-035 Collision: address 7 holds 64'hA; same cycle read 7 and write 64'hB with full mask -> q = 64'hA; next read -> 64'hB.
REQ-036 Power modes:
- deepsleep = 1 with a write of 64'h5 to address 3 -> write ignored; after exit, address 3 keeps its old value.
- powergate pulse -> q = 0 and every address reads 64'h0.
REQ-037 Hold and reset:
- cenA = 1 for 3 cycles while aA changes -> q unchanged.
- rst = 1 in the same cycle as a write to address 9 -> address 9 reads 0 and q = 0 after reset.
